// File: rtl/clock_period_meter_pkg.sv
// clock_period_meter_pkg: shared state encoding and default sizing for the period meter
package clock_period_meter_pkg;
   localparam int DEF_CNT_W = 30;
   localparam int DEF_TIMEOUT = 200000000;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MEASURE = 1'b1;
endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer plus history flop yielding single-cycle rise/fall strobes
module sync_edge_detect
   import clock_period_meter_pkg::*;
(
   input  logic clk_i,
   input  logic reset,
   input  logic sig_i,
   output logic rise,
   output logic fall
);
   logic meta, synced, hist;
   // shift the async input through the synchronizer and keep one cycle of history
   always_ff @(posedge clk_i) begin
      if (reset) begin
         meta <= 1'b0;
         synced <= 1'b0;
         hist <= 1'b0;
      end else begin
         meta <= sig_i;
         synced <= meta;
         hist <= synced;
      end
   end
   assign rise = synced & ~hist;
   assign fall = ~synced & hist;
endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of an async square wave in clk_i cycles
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)
(
   input  logic             clk_i,
   input  logic             reset,
   input  logic             en_i,
   input  logic             sig_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             timeout_o
);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);
   logic rise, fall;
   logic [0:0] state;
   logic [CNT_W-1:0] cnt, high_q, cnt_inc;
   sync_edge_detect u_sync (
      .clk_i (clk_i),
      .reset (reset),
      .sig_i (sig_i),
      .rise  (rise),
      .fall  (fall)
   );
   assign cnt_inc = cnt + CNT_W'(1);
   // arm on the first rise, then count cycles between rises; a rise on the terminal count still updates
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         high_q <= '0;
         period_o <= '0;
         high_o <= '0;
         valid_o <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (!en_i) begin
            state <= IDLE;
            cnt <= '0;
         end else if (state == IDLE) begin
            if (rise) begin
               cnt <= '0;
               state <= MEASURE;
            end
         end else if (rise) begin
            period_o <= cnt_inc;
            high_o <= high_q;
            cnt <= '0;
            valid_o <= 1'b1;
            timeout_o <= 1'b0;
         end else if (cnt == TERM) begin
            timeout_o <= 1'b1;
            cnt <= '0;
            state <= IDLE;
         end else begin
            cnt <= cnt_inc;
            if (fall) high_q <= cnt_inc;
         end
      end
   end
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed plus random waves checked against a timestamp-based reference model
module tb_clock_period_meter;
   localparam int W = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b0;
   logic sig = 1'b0;
   logic [W-1:0] per [2];
   logic [W-1:0] hi [2];
   logic val [2];
   logic tmo [2];
   int vectors = 0;
   int errs = 0;
   int edge_n = 0;
   logic sv [$];
   int armed [2], t_rise [2], hq [2], e_per [2], e_hi [2], e_val [2], e_to [2];

   always #5 clk = ~clk;

   clock_period_meter #(.CNT_W(W), .TIMEOUT(64)) dut (
      .clk_i(clk), .reset(reset), .en_i(en), .sig_i(sig),
      .period_o(per[0]), .high_o(hi[0]), .valid_o(val[0]), .timeout_o(tmo[0])
   );
   clock_period_meter #(.CNT_W(W), .TIMEOUT(10)) dut10 (
      .clk_i(clk), .reset(reset), .en_i(en), .sig_i(sig),
      .period_o(per[1]), .high_o(hi[1]), .valid_o(val[1]), .timeout_o(tmo[1])
   );

   function automatic int tlim(input int i);
      return i == 0 ? 64 : 10;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference: rise/fall seen when the sampled input (delayed two edges) changes; results from rise timestamps
   task automatic model(input logic s, input logic e, input logic r);
      int n;
      logic rise, fall;
      edge_n++;
      sv.push_back(r ? 1'b0 : s);
      n = sv.size();
      if (r) begin
         sv[n-2] = 1'b0;
         sv[n-3] = 1'b0;
      end
      rise = sv[n-3] && !sv[n-4];
      fall = !sv[n-3] && sv[n-4];
      for (int i = 0; i < 2; i++) begin
         e_val[i] = 0;
         if (r) begin
            armed[i] = 0; hq[i] = 0; e_per[i] = 0; e_hi[i] = 0; e_to[i] = 0;
         end else if (!e) armed[i] = 0;
         else if (armed[i] == 0) begin
            if (rise) begin
               armed[i] = 1;
               t_rise[i] = edge_n;
            end
         end else if (rise) begin
            e_per[i] = edge_n - t_rise[i];
            e_hi[i] = hq[i];
            e_val[i] = 1;
            e_to[i] = 0;
            t_rise[i] = edge_n;
         end else if (edge_n - t_rise[i] == tlim(i)) begin
            e_to[i] = 1;
            armed[i] = 0;
         end else if (fall) hq[i] = edge_n - t_rise[i];
      end
   endtask

   task automatic step(input logic s, input logic e, input logic r);
      @(negedge clk);
      sig = s;
      en = e;
      reset = r;
      @(posedge clk);
      model(s, e, r);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("valid%0d@%0d", i, edge_n), 32'(val[i]), e_val[i]);
         chk($sformatf("period%0d@%0d", i, edge_n), 32'(per[i]), e_per[i]);
         chk($sformatf("high%0d@%0d", i, edge_n), 32'(hi[i]), e_hi[i]);
         chk($sformatf("timeout%0d@%0d", i, edge_n), 32'(tmo[i]), e_to[i]);
      end
   endtask

   task automatic wave(input int p, input int h, input int n);
      for (int k = 0; k < n; k++)
         for (int c = 0; c < p; c++) step(c < h, 1'b1, 1'b0);
   endtask

   initial begin
      int p, h, n;
      repeat (4) sv.push_back(1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      chk("reset_period", 32'(per[0]), 0);
      chk("reset_timeout", 32'(tmo[0]), 0);
      wave(10, 4, 6);
      chk("p10_period", 32'(per[0]), 10);
      chk("p10_high", 32'(hi[0]), 4);
      chk("term_period", 32'(per[1]), 10);
      chk("term_timeout", 32'(tmo[1]), 0);
      wave(4, 2, 6);
      chk("p4_period", 32'(per[0]), 4);
      chk("p4_high", 32'(hi[0]), 2);
      repeat (70) step(1'b0, 1'b1, 1'b0);
      chk("timeout_set", 32'(tmo[0]), 1);
      wave(10, 4, 3);
      chk("timeout_clear", 32'(tmo[0]), 0);
      for (int c = 0; c < 5; c++) step(c < 4, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b1, 1'b0);
      chk("en_drop_hold", 32'(per[0]), 10);
      wave(10, 4, 3);
      for (int c = 0; c < 6; c++) step(c < 4, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      chk("mid_reset_period", 32'(per[0]), 0);
      chk("mid_reset_high", 32'(hi[0]), 0);
      wave(10, 4, 3);
      repeat (25) begin
         p = $urandom_range(4, 24);
         h = $urandom_range(1, p - 1);
         n = $urandom_range(2, 5);
         if ($urandom_range(0, 5) == 0) step(1'b0, 1'b0, 1'b0);
         wave(p, h, n);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
